register_unit: RTL and testbench



---
 rtl/rv32_pkg.sv | 14 +
 rtl/register_unit.sv | 68 ++++++
 tb/tb_register_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I core constants: datapath width, register index width and ABI register numbers.
package rv32_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd1;
  localparam logic [REG_IDX_W-1:0] REG_SP   = 5'd2;

  // Top of the initial stack: last word of a 4 KiB data region.
  localparam logic [XLEN-1:0] SP_RESET_VAL = 32'h0000_0FFC;

endpackage

// File: rtl/register_unit.sv
// RV32I integer register file: two combinational read ports plus a debug port, one write per clock.
// Reads have no write bypass; x0 reads zero and x2 comes out of reset holding the stack top.
module register_unit
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN    = rv32_pkg::XLEN,
  parameter int unsigned     NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = SP_RESET_VAL,
  parameter int unsigned     SP_IDX  = 32'(REG_SP)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] RS1,
  input  logic [$clog2(NREGS)-1:0] RS2,
  input  logic [$clog2(NREGS)-1:0] RD,
  input  logic [XLEN-1:0]          DataWr,
  input  logic                     RUWr,
  output logic [XLEN-1:0]          RU1,
  output logic [XLEN-1:0]          RU2,
  input  logic [$clog2(NREGS)-1:0] DbgAddr,
  output logic [XLEN-1:0]          DbgData,
  output logic [31:0]              WrCount
);

  if (SP_IDX == 0 || SP_IDX >= NREGS) begin : g_bad_sp_idx
    $error("register_unit: SP_IDX must be in 1..NREGS-1");
  end
  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("register_unit: NREGS must be a power of two and at least 2");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     wr_cnt_q;
  logic [31:0]     wr_cnt_d;
  logic            wr_commit;

  assign wr_commit = RUWr && (RD != '0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      regs_d[RD] = DataWr;
      wr_cnt_d   = wr_cnt_q + 32'd1;
    end
    // Slot 0 is pinned to zero so it folds away as constant logic.
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= (i == int'(SP_IDX)) ? SP_INIT : '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign RU1     = (RS1 == '0) ? '0 : regs_q[RS1];
  assign RU2     = (RS2 == '0) ? '0 : regs_q[RS2];
  assign DbgData = (DbgAddr == '0) ? '0 : regs_q[DbgAddr];
  assign WrCount = wr_cnt_q;

endmodule

// File: tb/tb_register_unit.sv
// Directed self-checking bench for register_unit.
module tb_register_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  RS1, RS2, RD, DbgAddr;
  logic [31:0] DataWr;
  logic        RUWr;
  logic [31:0] RU1, RU2, DbgData, WrCount;
  logic [3:0]  ALUOp;
  logic [31:0] ALURes;

  int n_checks = 0;
  int n_fail   = 0;

  register_unit dut (
    .clk     (clk),
    .rst     (rst),
    .RS1     (RS1),
    .RS2     (RS2),
    .RD      (RD),
    .DataWr  (DataWr),
    .RUWr    (RUWr),
    .RU1     (RU1),
    .RU2     (RU2),
    .DbgAddr (DbgAddr),
    .DbgData (DbgData),
    .WrCount (WrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small ALU covering the two operations used here (ADD / SUB encodings).
  always_comb begin
    ALURes = 32'h0;
    case (ALUOp)
      4'b0000: ALURes = RU1 + RU2;
      4'b1000: ALURes = RU1 - RU2;
      default: ALURes = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    RD     = rd;
    DataWr = data;
    RUWr   = 1'b1;
    tick();
    RUWr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; RUWr = 1'b0; RD = 5'd0; DataWr = 32'h0;
    RS1 = 5'd2; RS2 = 5'd5; DbgAddr = 5'd0; ALUOp = 4'b0000;
    #2;
    check("reset_ru1_sp", RU1, 32'h0000_0FFC);
    check("reset_ru2", RU2, 32'h0);
    check("reset_wrcount", WrCount, 32'h0);
    for (int i = 0; i < 32; i++) begin
      DbgAddr = 5'(i);
      #1;
      check($sformatf("reset_dbg_x%0d", i), DbgData, (i == 2) ? 32'h0000_0FFC : 32'h0);
    end

    @(negedge clk);
    rst = 1'b0;

    // Basic write; value must not appear before the edge.
    RS1 = 5'd5; RD = 5'd5; DataWr = 32'hDEAD_BEEF; RUWr = 1'b1;
    #1;
    check("no_bypass", RU1, 32'h0);
    tick();
    RUWr = 1'b0;
    check("write_x5", RU1, 32'hDEAD_BEEF);
    check("wrcount_1", WrCount, 32'd1);

    // x0 protection
    RS1 = 5'd0;
    write_reg(5'd0, 32'hFFFF_FFFF);
    check("x0_ru1", RU1, 32'h0);
    DbgAddr = 5'd0; #1;
    check("x0_dbg", DbgData, 32'h0);
    check("x0_wrcount", WrCount, 32'd1);

    // Write-enable gating
    RS2 = 5'd7; RD = 5'd7; DataWr = 32'h1234_5678; RUWr = 1'b0;
    tick();
    check("ruwr0_x7", RU2, 32'h0);
    check("ruwr0_wrcount", WrCount, 32'd1);
    RUWr = 1'b1;
    tick();
    RUWr = 1'b0;
    check("ruwr1_x7", RU2, 32'h1234_5678);
    check("ruwr1_wrcount", WrCount, 32'd2);
    RS1 = 5'd7; #1;
    check("dual_read_ru1", RU1, 32'h1234_5678);
    check("dual_read_ru2", RU2, 32'h1234_5678);

    // Unknown data with write disabled must not disturb state
    DataWr = 'x; RD = 5'd7; RUWr = 1'b0;
    tick();
    check("x_data_gated", RU2, 32'h1234_5678);
    check("x_data_wrcount", WrCount, 32'd2);

    // Async reset mid-operation
    write_reg(5'd3, 32'hA5A5_A5A5);
    write_reg(5'd2, 32'h0000_0010);
    RS1 = 5'd3; RS2 = 5'd2; #1;
    check("pre_rst_x3", RU1, 32'hA5A5_A5A5);
    check("pre_rst_x2", RU2, 32'h0000_0010);
    check("pre_rst_wrcount", WrCount, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_x3", RU1, 32'h0);
    check("async_rst_x2", RU2, 32'h0000_0FFC);
    check("async_rst_wrcount", WrCount, 32'h0);
    RD = 5'd3; DataWr = 32'h0000_BEEF; RUWr = 1'b1;
    tick();
    RUWr = 1'b0;
    check("rst_write_dropped", RU1, 32'h0);
    check("rst_write_wrcount", WrCount, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ALU hookup: x1 - x4 written back to x6
    write_reg(5'd1, 32'd10);
    write_reg(5'd4, 32'd5);
    RS1 = 5'd1; RS2 = 5'd4; ALUOp = 4'b1000; #1;
    check("alu_sub", ALURes, 32'd5);
    RD = 5'd6; DataWr = ALURes; RUWr = 1'b1;
    tick();
    RUWr = 1'b0;
    DbgAddr = 5'd6; #1;
    check("writeback_x6", DbgData, 32'd5);
    check("final_wrcount", WrCount, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
